seq_signed_multiplier: RTL and testbench
========================================

Name: seq_signed_multiplier

Overview:
Sequential shift-add multiplier for two's-complement operands. It sits directly downstream of the push-button pulse stage. That stage's single-cycle "out" pulse drives this block's start input. The block latches the switch-supplied operands, multiplies their magnitudes over N iterations, applies the sign, and holds the product for the display path until the next start.

Parameters:
N, 8, operand width in bits (signed); product width is 2*N.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse from the push-button pulse stage; sampled only in IDLE.
multiplicand  input  N  signed operand A; sampled on the accepted start edge only.
multiplier  input  N  signed operand B; sampled on the accepted start edge only.
product  output  2*N  signed result; held until the next accepted start.
product_neg  output  1  1 when product is strictly negative; for the display sign digit.
busy  output  1  high while a multiplication is in progress.
done  output  1  one-cycle pulse when product becomes valid.

Behaviour:
- Reset: rst=1 at a rising edge forces state=IDLE and clears all registers. After reset: product=0, product_neg=0, busy=0, done=0. rst has priority over every other input, including mid-operation; the aborted operation produces no done.
- States:
  - IDLE: start=1 goes to RUN.
  - RUN: stays in RUN until iteration counter reaches N-1, then goes to SIGN.
  - SIGN: goes to IDLE unconditionally.
- Accepted start (edge k, state IDLE):
  - Latch mag_a=|A| and mag_b=|B| as N-bit unsigned; |-2^(N-1)| = 2^(N-1) fits unsigned.
  - Latch neg = A[N-1] XOR B[N-1].
  - Clear acc (2N bits unsigned) and cnt.
  - Set busy=1; product keeps its old value.
- RUN (edges k+1 .. k+N), one iteration per cycle:
  - If mag_b[0]=1: acc = acc + (mag_a zero-extended to 2N, shifted left by cnt). Implementation may shift mag_a in place instead.
  - mag_b >>= 1; cnt++.
- SIGN (edge k+N+1):
  - product = neg ? -acc : acc (2N-bit two's complement).
  - product_neg = neg AND (acc != 0); zero is never negative.
  - done=1 for exactly this following cycle; busy=0 from the same edge.
- Latency: done is visible N+1 cycles after the accepted start edge (9 for N=8). busy is high for exactly N+1 cycles.
- start while busy: ignored entirely. The operation is not restarted, and no queued start is kept.
- start on the cycle done is high: the state is already IDLE, so the start is accepted.
- Operand changes after the accepted start edge have no effect on the running result.
- Width rules: the magnitude product is at most 2^(2N-2), which fits without overflow.
  - -2^(N-1) * -2^(N-1) = +2^(2N-2) is representable (0x4000 for N=8).
  - No saturation logic is needed.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, SIGN} with 2-bit encoding.
  - Default N constant.
  - Counter width constant = clog2(N).
- One natural sub-module: sign_magnitude_split, a combinational unit giving N-bit signed in -> N-bit unsigned magnitude + sign bit. It is instantiated twice for A and B.
- Control FSM and datapath stay in the top module.

Test Plan:
1. rst held 2 cycles, then released -> product=0x0000, product_neg=0, busy=0, done=0. Then A=5, B=3, start pulse -> busy high 9 cycles; done pulses on the 9th cycle after start; product=0x000F; product_neg=0.
2. A=-7 (0xF9), B=6 -> product=0xFFD6 (-42), product_neg=1. A=-128 (0x80), B=-128 -> product=0x4000, product_neg=0. A=127, B=-128 -> product=0xC080 (-16256), product_neg=1.
3. A=0, B=-5 -> product=0x0000, product_neg=0, done after 9 cycles.
4. A=3, B=4, start. Then start pulses at cycles 3 and 8 with A=9, B=9, and operands changed mid-run -> exactly one done; product=0x000C. A start in the done cycle, with A=2, B=2, is accepted and yields 0x0004 nine cycles later.
5. Start A=10, B=10; assert rst at cycle 4 for one cycle -> no done ever; product=0, busy=0 after that edge. A new start with A=-1, B=-1 gives product=0x0001 after 9 cycles.

Source files
------------

// File: rtl/seq_signed_multiplier_pkg.sv
// Shared definitions for the sequential signed multiplier.
//   state_t    : control FSM states, 2-bit encoding
//   N_DEFAULT  : default operand width
//   cnt_width  : iteration counter width for a given operand width
//   CNT_W      : counter width for the default operand width
package seq_signed_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  localparam int N_DEFAULT = 8;

  // At least one bit, so that an N=1 build still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(N_DEFAULT);

endpackage

// File: rtl/seq_signed_multiplier_sign_magnitude_split.sv
// Combinational two's-complement to sign/magnitude converter.
//   value : N-bit signed input
//   mag   : N-bit unsigned magnitude (|-2^(N-1)| = 2^(N-1) fits unsigned)
//   sign  : 1 when value is negative
module sign_magnitude_split #(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  output logic [N-1:0] mag,
  output logic         sign
);

  assign sign = value[N-1];
  // Negating the most negative value wraps back to the same bit pattern,
  // which read as unsigned is exactly its magnitude.
  assign mag  = sign ? (-value) : value;

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sequential shift-add multiplier for two's-complement operands.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   start        : single-cycle request pulse, honoured only in IDLE
//   multiplicand : signed operand A, sampled on the accepted start edge
//   multiplier   : signed operand B, sampled on the accepted start edge
//   product      : signed 2N-bit result, held until the next accepted start
//   product_neg  : 1 when product is strictly negative
//   busy         : high while a multiplication is in progress (N+1 cycles)
//   done         : one-cycle pulse when product becomes valid
module seq_signed_multiplier
  import seq_signed_multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [2*N-1:0]   product,
  output logic             product_neg,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(N);

  state_t          state, next_state;
  logic [N-1:0]    mag_a_in, mag_b_in;
  logic            sign_a, sign_b;
  logic [2*N-1:0]  mag_a_sh;   // magnitude of A, shifted left once per iteration
  logic [N-1:0]    mag_b;      // magnitude of B, shifted right once per iteration
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            last_iter;

  sign_magnitude_split #(.N(N)) u_split_a (
    .value (multiplicand),
    .mag   (mag_a_in),
    .sign  (sign_a)
  );

  sign_magnitude_split #(.N(N)) u_split_b (
    .value (multiplier),
    .mag   (mag_b_in),
    .sign  (sign_b)
  );

  assign last_iter = (cnt == CW'(N - 1));
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_iter) next_state = SIGN;
      SIGN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every datapath register is cleared on reset; nothing here is a
  // memory array, so a full clear is cheap and keeps outputs defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a_sh    <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      product     <= '0;
      product_neg <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mag_a_sh <= {{N{1'b0}}, mag_a_in};
            mag_b    <= mag_b_in;
            neg      <= sign_a ^ sign_b;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (mag_b[0]) acc <= acc + mag_a_sh;
          mag_a_sh <= mag_a_sh << 1;
          mag_b    <= mag_b >> 1;
          cnt      <= cnt + CW'(1);
        end
        SIGN: begin
          product     <= neg ? (-acc) : acc;
          // A zero magnitude is never reported as negative.
          product_neg <= neg & (acc != '0);
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier: directed corner cases plus
// randomized operands, with a queue-based scoreboard checked on every done.
module tb_seq_signed_multiplier;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     multiplicand = '0;
  logic [N-1:0]     multiplier = '0;
  logic [2*N-1:0]   product;
  logic             product_neg;
  logic             busy;
  logic             done;

  int               n_checks = 0;
  int               n_fail = 0;
  bit               mon_en = 1'b0;
  logic [2*N-1:0]   exp_q[$];
  logic [2*N-1:0]   last_product = '0;

  seq_signed_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .product_neg  (product_neg),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed multiplication at product width.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        logic [2*N-1:0] e;
        e = exp_q.pop_front();
        check("product", 32'(product), 32'(e));
        check("product_neg", 32'(product_neg), 32'($signed(e) < 0));
      end
    end
  end

  // Issue one operation and wait (bounded) for its done. With inject set,
  // extra start pulses land while busy; operands are scrambled mid-run always.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit inject);
    logic [2*N-1:0] e;
    int latency;
    e = model(a, b);
    exp_q.push_back(e);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("product_held", 32'(product), 32'(last_product));
    latency = 0;
    for (int i = 1; i <= 20; i++) begin
      check("busy_high", 32'(busy), 32'(1));
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      start        = inject && (i == 3 || i == 8);
      tick();
      if (done === 1'b1) begin
        latency = i;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", 32'(latency), 32'(N + 1));
    check("busy_low_at_done", 32'(busy), 32'(0));
    last_product = e;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [N-1:0] corners[5];
    int done_seen;
    corners[0] = 8'h80; corners[1] = 8'h7F; corners[2] = 8'h00;
    corners[3] = 8'hFF; corners[4] = 8'h01;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_product", 32'(product), 32'(0));
    check("rst_product_neg", 32'(product_neg), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    mon_en = 1'b1;

    // Directed products and sign corners
    run_op(8'd5, 8'd3, 1'b0);
    check("p_5x3", 32'(product), 32'h000F);
    tick();
    run_op(8'hF9, 8'd6, 1'b0);
    check("p_m7x6", 32'(product), 32'hFFD6);
    run_op(8'h80, 8'h80, 1'b0);
    check("p_m128xm128", 32'(product), 32'h4000);
    run_op(8'd127, 8'h80, 1'b0);
    check("p_127xm128", 32'(product), 32'hC080);
    run_op(8'd0, 8'hFB, 1'b0);
    check("p_0xm5_neg", 32'(product_neg), 32'(0));

    // Starts while busy are ignored; start in the done cycle is accepted
    tick();
    run_op(8'd3, 8'd4, 1'b1);
    check("p_3x4_ignored_starts", 32'(product), 32'h000C);
    run_op(8'd2, 8'd2, 1'b0);
    check("p_2x2_done_cycle", 32'(product), 32'h0004);

    // Reset mid-operation aborts with no done
    tick();
    multiplicand = 8'd10;
    multiplier   = 8'd10;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_product = '0;
    check("abort_product", 32'(product), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'(0));
    run_op(8'hFF, 8'hFF, 1'b0);
    check("p_m1xm1", 32'(product), 32'h0001);

    // Randomized operands with corner injection and random gaps
    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] a, b;
      int gap;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : N'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : N'($urandom);
      run_op(a, b, bit'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("done_one_cycle", 32'(done), 32'(0));
      end
    end

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
